// File: rtl/calc_sequencer.sv
// calc_sequencer: control FSM for signed multiply, BCD load and windowed display scroll.
// Optional Multiplier timeout when CALC_MUL_TIMEOUT_EN is defined.
module calc_sequencer #(
   parameter int WIDTH = 8,
   parameter int DIGITS = 5,
   parameter int WINDOW = 4,
   parameter int TIMEOUT = 64,
   localparam int PW = (DIGITS - WINDOW + 1) > 1 ? $clog2(DIGITS - WINDOW + 1) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      op_a,
   input  logic [WIDTH-1:0]      op_b,
   input  logic                  scroll_left,
   input  logic                  scroll_right,
   output logic [WIDTH-1:0]      mul_a,
   output logic [WIDTH-1:0]      mul_b,
   output logic                  mul_start,
   input  logic                  mul_done,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic [4*DIGITS-1:0]   sr_num,
   output logic                  sr_load,
   output logic                  sr_en,
   output logic                  sr_dir,
   output logic                  neg,
   output logic [PW-1:0]         pos,
   output logic                  busy,
   output logic                  valid,
   output logic                  err
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] MUL   = 3'd1;
   localparam logic [2:0] CONV  = 3'd2;
   localparam logic [2:0] LOAD  = 3'd3;
   localparam logic [2:0] SHOW  = 3'd4;
   localparam logic [2:0] SHIFT = 3'd5;
   localparam logic [PW-1:0] POS_MAX = PW'(DIGITS - WINDOW);
   logic [2:0] state;
   logic take, go_left, go_right;
   assign take = start && (state == IDLE || state == SHOW);
   assign go_left = scroll_left && !scroll_right && pos < POS_MAX;
   assign go_right = scroll_right && !scroll_left && pos != '0;
   assign mul_start = state == MUL;
   assign sr_load = state == LOAD;
   assign sr_en = state == SHIFT;
   assign valid = state == SHOW;
   assign busy = state == MUL || state == CONV || state == LOAD || state == SHIFT;
`ifdef CALC_MUL_TIMEOUT_EN
   localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0] cnt;
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (take) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (state == MUL) begin
         cnt <= cnt + TW'(1);
         if (!mul_done && cnt == TW'(TIMEOUT - 1)) err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         mul_a <= '0;
         mul_b <= '0;
         sr_num <= '0;
         sr_dir <= 1'b0;
         neg <= 1'b0;
         pos <= '0;
      end else if (take) begin
         mul_a <= op_a[WIDTH-1] ? -op_a : op_a;
         mul_b <= op_b[WIDTH-1] ? -op_b : op_b;
         neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
         state <= MUL;
      end else begin
         case (state)
            MUL: begin
               if (mul_done) state <= CONV;
`ifdef CALC_MUL_TIMEOUT_EN
               else if (cnt == TW'(TIMEOUT - 1)) state <= IDLE;
`endif
            end
            CONV: begin
               sr_num <= bcd_in;
               if (bcd_in == '0) neg <= 1'b0;
               state <= LOAD;
            end
            LOAD: begin
               pos <= '0;
               state <= SHOW;
            end
            SHOW: begin
               if (go_left) begin
                  sr_dir <= 1'b1;
                  pos <= pos + PW'(1);
                  state <= SHIFT;
               end else if (go_right) begin
                  sr_dir <= 1'b0;
                  pos <= pos - PW'(1);
                  state <= SHIFT;
               end
            end
            SHIFT: state <= SHOW;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: table-driven vectors plus scroll, reset and timeout sequences.
module tb_calc_sequencer;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, scroll_left = 1'b0, scroll_right = 1'b0, mul_done = 1'b0;
   logic [7:0] op_a = '0, op_b = '0;
   logic [19:0] bcd_in = '0;
   logic [7:0] mul_a, mul_b;
   logic [19:0] sr_num;
   logic mul_start, sr_load, sr_en, sr_dir, neg, busy, valid, err;
   logic [0:0] pos;
   int n_vec = 0, n_bad = 0;
   always #5 clk = ~clk;
   calc_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
      .scroll_left(scroll_left), .scroll_right(scroll_right),
      .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_done(mul_done),
      .bcd_in(bcd_in), .sr_num(sr_num), .sr_load(sr_load), .sr_en(sr_en), .sr_dir(sr_dir),
      .neg(neg), .pos(pos), .busy(busy), .valid(valid), .err(err)
   );
   typedef struct {
      logic [7:0] a, b, ma, mb;
      logic [19:0] bcd;
      logic neg_mul, neg_fin;
   } vec_t;
   vec_t v[6];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic go(input logic [7:0] a, input logic [7:0] b);
      op_a = a;
      op_b = b;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask
   initial begin
      v[0] = '{8'hFB, 8'h0A, 8'h05, 8'h0A, 20'h00050, 1'b1, 1'b1};
      v[1] = '{8'h00, 8'hF9, 8'h00, 8'h07, 20'h00000, 1'b1, 1'b0};
      v[2] = '{8'h80, 8'h80, 8'h80, 8'h80, 20'h16384, 1'b0, 1'b0};
      v[3] = '{8'h7F, 8'hFF, 8'h7F, 8'h01, 20'h00127, 1'b1, 1'b1};
      v[4] = '{8'h0C, 8'h0C, 8'h0C, 8'h0C, 20'h00144, 1'b0, 1'b0};
      v[5] = '{8'hFD, 8'h00, 8'h03, 8'h00, 20'h00000, 1'b1, 1'b0};
      step();
      step();
      chk("reset_outputs", {mul_a, mul_b, sr_num, mul_start, sr_load, sr_en, sr_dir, neg, pos, busy, valid, err}, 64'd0);
      rst = 1'b1;
      step();
      chk("idle_after_reset", {busy, valid, mul_start}, 3'b000);
      for (int i = 0; i < 6; i++) begin
         go(v[i].a, v[i].b);
         chk("mul_entry", {mul_start, busy, valid}, 3'b110);
         chk("mul_a", mul_a, v[i].ma);
         chk("mul_b", mul_b, v[i].mb);
         chk("neg_mul", neg, v[i].neg_mul);
         step();
         chk("mul_wait", mul_start, 1'b1);
         mul_done = 1'b1;
         bcd_in = v[i].bcd;
         step();
         mul_done = 1'b0;
         chk("conv", {busy, mul_start, sr_load}, 3'b100);
         step();
         chk("load", {sr_load, busy, valid}, 3'b110);
         chk("sr_num", sr_num, v[i].bcd);
         chk("neg_fin", neg, v[i].neg_fin);
         step();
         chk("show", {valid, busy, sr_load, sr_en}, 4'b1000);
         chk("pos0", pos, 1'b0);
      end
      scroll_right = 1'b1;
      step();
      scroll_right = 1'b0;
      chk("right_at_0", {valid, sr_en, pos}, 3'b100);
      scroll_left = 1'b1;
      step();
      chk("left_shift", {sr_en, sr_dir, pos, busy, valid}, 5'b11110);
      step();
      scroll_left = 1'b0;
      chk("left_back", {valid, sr_en, pos, sr_dir}, 4'b1011);
      scroll_left = 1'b1;
      step();
      scroll_left = 1'b0;
      chk("left_at_max", {valid, sr_en, pos}, 3'b101);
      scroll_right = 1'b1;
      step();
      scroll_right = 1'b0;
      chk("right_shift", {sr_en, sr_dir, pos}, 3'b100);
      step();
      chk("right_back", {valid, sr_en, pos}, 3'b100);
      scroll_left = 1'b1;
      scroll_right = 1'b1;
      step();
      scroll_left = 1'b0;
      scroll_right = 1'b0;
      chk("both_scroll", {valid, sr_en, pos}, 3'b100);
      scroll_left = 1'b1;
      go(8'hFB, 8'h0A);
      scroll_left = 1'b0;
      chk("start_over_scroll", {mul_start, sr_en, valid, pos}, 4'b1000);
      go(8'h03, 8'h03);
      chk("start_in_mul_ign", {mul_a, mul_b, neg, mul_start}, {8'h05, 8'h0A, 1'b1, 1'b1});
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("reset_mid_mul", {mul_a, mul_b, sr_num, mul_start, sr_load, sr_en, sr_dir, neg, pos, busy, valid, err}, 64'd0);
      mul_done = 1'b1;
      step();
      step();
      mul_done = 1'b0;
      chk("no_load_after_rst", {sr_load, busy, valid}, 3'b000);
`ifdef CALC_MUL_TIMEOUT_EN
      go(8'h02, 8'h03);
      for (int i = 0; i < 63; i++) step();
      chk("mul_cycle_64", {mul_start, err}, 2'b10);
      step();
      chk("timeout", {err, mul_start, busy, valid}, 4'b1000);
      go(8'h02, 8'h03);
      chk("err_cleared", {err, mul_start}, 2'b01);
      for (int i = 0; i < 63; i++) step();
      mul_done = 1'b1;
      step();
      mul_done = 1'b0;
      chk("done_beats_timeout", {err, busy, mul_start}, 3'b010);
      step();
      step();
`else
      go(8'h02, 8'h03);
      for (int i = 0; i < 80; i++) step();
      chk("no_timeout", {err, mul_start}, 2'b01);
      mul_done = 1'b1;
      step();
      mul_done = 1'b0;
      step();
      step();
`endif
      chk("final_show", {valid, err}, 2'b10);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Control FSM for the signed multiply-and-display path. It captures two signed operands, converts them to magnitude plus result sign, and runs the unsigned Multiplier. It then latches the DoubleDabble BCD of the product and loads it into the bidirectional BCD shift register. After that it scrolls a display window across the result digits on user pulses.

## Interface
- WIDTH, 8, operand width; operands are two's complement.
- DIGITS, 5, number of BCD digits in the product; the shift-register bus is 4*DIGITS bits.
- WINDOW, 4, number of digits visible at once; scroll positions are 0..DIGITS-WINDOW.
- TIMEOUT, 64, maximum MUL cycles allowed before error; only used with CALC_MUL_TIMEOUT_EN.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin a new calculation; sampled in IDLE and SHOW only.
- op_a, op_b  in  WIDTH  signed operands, sampled on an accepted start.
- scroll_left, scroll_right  in  1  single-cycle scroll requests; sampled in SHOW only.
- mul_a, mul_b  out  WIDTH  registered unsigned magnitudes to the Multiplier.
- mul_start  out  1  held high for the whole MUL state.
- mul_done  in  1  Multiplier completion.
- bcd_in  in  4*DIGITS  DoubleDabble output of the product.
- sr_num  out  4*DIGITS  registered BCD value for the shift register.
- sr_load  out  1  shift-register parallel load.
- sr_en  out  1  shift-register enable; one digit moves per enabled cycle.
- sr_dir  out  1  shift direction: 1 = left (pos increments), 0 = right.
- neg  out  1  result sign.
- pos  out  clog2(DIGITS-WINDOW+1), minimum 1  current scroll position.
- busy  out  1  high in MUL, CONV, LOAD and SHIFT.
- valid  out  1  high in SHOW only.
- err  out  1  sticky Multiplier timeout flag.

## Operation
- Reset value of every output is 0. State is IDLE and the internal counters are 0.
- States are IDLE, MUL, CONV, LOAD, SHOW and SHIFT.
- **IDLE**, on start:
  - register mul_a = |op_a| and mul_b = |op_b|; -128 gives 0x80 unsigned.
  - register neg = sign(op_a) XOR sign(op_b).
  - clear err and the timeout counter, then go to MUL.
- **MUL**: mul_start = 1. When mul_done is sampled high, go to CONV.
- **CONV**:
  - sr_num <= bcd_in.
  - If bcd_in is all zeros, force neg = 0.
  - Go to LOAD.
- **LOAD**: sr_load = 1 for one cycle, pos <= 0, then go to SHOW.
- **SHOW**: valid = 1. Inputs are handled as follows:
  - start is handled exactly as in IDLE; valid drops on the next cycle.
  - scroll_left alone with pos < DIGITS-WINDOW: go to SHIFT with sr_dir = 1 and pos + 1.
  - scroll_right alone with pos > 0: go to SHIFT with sr_dir = 0 and pos - 1.
  - start takes priority over a scroll request in the same cycle.
  - Scroll requests at the limit, or both scroll requests together, are ignored.
- **SHIFT**: sr_en = 1 for exactly one cycle, then return to SHOW. sr_dir is held stable during SHIFT.
- start in MUL, CONV, LOAD or SHIFT is ignored and not queued. Scroll pulses outside SHOW are dropped.
- Reset deasserted-low at any edge returns all outputs to 0 on that edge, including mid-MUL. mul_start drops immediately.

## Timing
- Start sampled at edge N puts the block in MUL during cycle N+1, with mul_start high.
- mul_done sampled high at edge M gives:
  - CONV in cycle M+1,
  - sr_load in cycle M+2,
  - valid in cycle M+3.
- Minimum start-to-valid latency is the Multiplier latency plus 3 cycles.
- A scroll step takes 2 cycles: sr_en is high in the cycle after the request, and SHOW resumes the cycle after that. pos updates on the request edge.
- mul_a, mul_b and neg are stable from MUL entry until the next accepted start.

## Configuration
- CALC_MUL_TIMEOUT_EN defined:
  - A counter runs in MUL.
  - If TIMEOUT cycles pass without mul_done, set err = 1, drop mul_start and go to IDLE.
  - mul_done arriving in the same cycle as expiry wins, and there is no error.
- CALC_MUL_TIMEOUT_EN undefined: err is tied to 0, the counter is not built, and MUL waits indefinitely.

## Test plan
- op_a = -5, op_b = 10, start -> mul_a = 5, mul_b = 10, neg = 1, sr_num = 0x00050, one sr_load pulse, then valid = 1.
- op_a = 0, op_b = -7 -> neg = 0 at valid; sr_num = 0x00000.
- op_a = -128, op_b = -128 -> mul_a = mul_b = 0x80, sr_num = 0x16384, neg = 0.
- In SHOW with pos = 0 (DIGITS = 5, WINDOW = 4), pulse scroll_left twice -> one sr_en pulse with sr_dir = 1 and pos = 1; the second pulse is ignored. scroll_right -> sr_en with sr_dir = 0 and pos = 0. Both pulses together -> no sr_en.
- With CALC_MUL_TIMEOUT_EN, start with mul_done held at 0 -> err = 1 and IDLE after 64 MUL cycles. The next start clears err.
- rst = 0 for one edge in MUL -> all outputs 0 the next cycle, with no sr_load. start during MUL -> ignored.
